// File: rtl/credit_issuer_pkg.sv
// Shared types and defaults for the receiver-side credit issuer.
// The output record mirrors what the sender-side credit counter consumes.
package credit_issuer_pkg;

   localparam int unsigned CREDITS_RETURN_BATCH   = 4;
   localparam int unsigned CREDITS_RETURN_TIMEOUT = 16;
   localparam int unsigned OCC_W                  = 7;
   localparam int unsigned PEND_W                 = 9;

   typedef struct packed {
      logic              valid_request;
      logic              valid_response;
      logic [PEND_W-1:0] response_credits;
      logic [7:0]        room;
   } credit_interface_input_t;

   typedef enum logic [1:0] {
      StIdle,
      StAnnounce,
      StRun
   } credit_issuer_state_t;

endpackage

// File: rtl/credit_fifo.sv
// Request buffer with explicit pointer wrap so any depth in 1..64 works.
// Head data reads as zero while empty so nothing stale leaks out after reset.
module credit_fifo
   import credit_issuer_pkg::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 32
) (
   input  logic             clock,
   input  logic             rstn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [OCC_W-1:0] count,
   output logic [WIDTH-1:0] head_data
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [OCC_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign empty     = (count_q == '0);
   assign full      = (count_q == OCC_W'(DEPTH));
   assign count     = count_q;
   assign head_data = empty ? '0 : mem[rd_ptr_q];

   // A pop frees the slot in the same cycle, so a push at full is legal alongside it.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (do_pop) rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
      if (do_push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/credit_issuer.sv
// Receiver end of the credit link: announces room, buffers requests, drains them
// downstream and returns freed credits to the sender in batches or on timeout.
module credit_issuer
   import credit_issuer_pkg::*;
#(
   parameter logic [7:0]  ROOM           = 8'h20,
   parameter int unsigned CMD_WIDTH      = 64,
   parameter int unsigned RETURN_BATCH   = CREDITS_RETURN_BATCH,
   parameter int unsigned RETURN_TIMEOUT = CREDITS_RETURN_TIMEOUT
) (
   input  logic                    clock,
   input  logic                    rstn,
   input  logic                    enable,
   input  logic                    request_valid,
   input  logic [CMD_WIDTH-1:0]    request_payload,
   output logic                    cmd_out_valid,
   output logic [CMD_WIDTH-1:0]    cmd_out_payload,
   input  logic                    cmd_out_ready,
   output credit_interface_input_t credit_out,
   output logic [OCC_W-1:0]        occupancy,
   output logic                    overrun_error
);

   localparam logic [7:0] TIMER_MAX = 8'(RETURN_TIMEOUT - 1);

   credit_issuer_state_t state_q, state_d;
   logic [PEND_W-1:0] pending_q, pending_d;
   logic [7:0]        timer_q, timer_d;
   logic              echo_q, overrun_q, overrun_d;
   logic              running, full, empty, pop, push, ret;

   credit_fifo #(
      .WIDTH (CMD_WIDTH),
      .DEPTH (int'(ROOM))
   ) u_fifo (
      .clock     (clock),
      .rstn      (rstn),
      .push      (push),
      .push_data (request_payload),
      .pop       (pop),
      .full      (full),
      .empty     (empty),
      .count     (occupancy),
      .head_data (cmd_out_payload)
   );

   assign cmd_out_valid = ~empty;
   assign pop           = cmd_out_valid & cmd_out_ready;
   assign running       = (state_q == StRun);
   assign push          = running & request_valid & (~full | pop);
   assign overrun_d     = overrun_q | (running & request_valid & full & ~pop);
   assign overrun_error = overrun_q;

   // Return decision looks only at registered state; a pop in the return cycle carries over.
   assign ret = (pending_q >= PEND_W'(RETURN_BATCH)) ||
                ((pending_q != '0) && (timer_q == TIMER_MAX));

   always_comb begin
      pending_d = ret ? PEND_W'(pop) : pending_q + PEND_W'(pop);
      if (ret || pending_q == '0) timer_d = '0;
      else if (timer_q == TIMER_MAX) timer_d = timer_q;
      else timer_d = timer_q + 8'd1;
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         state_q   <= StIdle;
         pending_q <= '0;
         timer_q   <= '0;
         echo_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         timer_q   <= timer_d;
         echo_q    <= push;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:     if (enable) state_d = StAnnounce;
         StAnnounce: state_d = StRun;
         StRun:      state_d = StRun;
         default:    state_d = StIdle;
      endcase
   end

   always_comb begin
      credit_out                  = '0;
      credit_out.room             = (state_q != StIdle) ? ROOM : 8'h00;
      credit_out.valid_request    = echo_q;
      credit_out.valid_response   = ret;
      credit_out.response_credits = ret ? pending_q : '0;
   end

`ifndef SYNTHESIS
   logic [9:0] cons_sum;
   assign cons_sum = 10'(occupancy) + 10'(pending_q);

   occupancy_bound_a : assert property (@(posedge clock) disable iff (!rstn)
      cons_sum <= 10'(ROOM));
   nonzero_return_a : assert property (@(posedge clock) disable iff (!rstn)
      credit_out.valid_response |-> (credit_out.response_credits != '0));
`endif

endmodule

// File: tb/tb_credit_issuer.sv
// Self-checking bench for credit_issuer: a cycle model with a payload scoreboard
// checks every cycle, plus directed checks for batching, timeout, overrun and reset.
module tb_credit_issuer;
   import credit_issuer_pkg::*;

   logic                    clock = 1'b0;
   logic                    rstn = 1'b1;
   logic                    enable = 1'b0;
   logic                    request_valid = 1'b0;
   logic [63:0]             request_payload = '0;
   logic                    cmd_out_valid;
   logic [63:0]             cmd_out_payload;
   logic                    cmd_out_ready = 1'b0;
   credit_interface_input_t credit_out;
   logic [6:0]              occupancy;
   logic                    overrun_error;

   credit_issuer dut (
      .clock           (clock),
      .rstn            (rstn),
      .enable          (enable),
      .request_valid   (request_valid),
      .request_payload (request_payload),
      .cmd_out_valid   (cmd_out_valid),
      .cmd_out_payload (cmd_out_payload),
      .cmd_out_ready   (cmd_out_ready),
      .credit_out      (credit_out),
      .occupancy       (occupancy),
      .overrun_error   (overrun_error)
   );

   always #5 clock = ~clock;

   int n_compared = 0;
   int n_mismatched = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model state
   logic [63:0] sb_q[$];
   int m_state = 0;
   int m_pend = 0;
   int m_tmr = 0;
   bit m_echo = 0;
   bit m_overrun = 0;

   // Observed statistics
   int cyc = 0;
   int echo_cnt = 0;
   int resp_cnt = 0;
   int resp_sum = 0;
   int last_pop_cyc = 0;
   int last_resp_cyc = 0;
   int resp_log[$];

   always @(negedge clock) begin
      bit exp_valid, m_ret, m_pop, m_full, m_push;
      if (!rstn) begin
         sb_q.delete();
         m_state = 0; m_pend = 0; m_tmr = 0; m_echo = 0; m_overrun = 0;
         check_eq("rst_valid", cmd_out_valid, 0);
         check_eq("rst_room", credit_out.room, 0);
         check_eq("rst_resp", credit_out.valid_response, 0);
         check_eq("rst_occ", occupancy, 0);
      end else begin
         exp_valid = (sb_q.size() != 0);
         m_ret = (m_pend >= 4) || (m_pend > 0 && m_tmr == 15);
         check_eq("room", credit_out.room, (m_state != 0) ? 64'h20 : 64'h0);
         check_eq("cmd_out_valid", cmd_out_valid, exp_valid);
         check_eq("occupancy", occupancy, sb_q.size());
         if (exp_valid) check_eq("payload", cmd_out_payload, sb_q[0]);
         check_eq("valid_request", credit_out.valid_request, m_echo);
         check_eq("valid_response", credit_out.valid_response, m_ret);
         check_eq("response_credits", credit_out.response_credits, m_ret ? m_pend : 0);
         check_eq("overrun_error", overrun_error, m_overrun);

         if (credit_out.valid_request) echo_cnt++;
         if (credit_out.valid_response) begin
            resp_cnt++;
            resp_sum += int'(credit_out.response_credits);
            resp_log.push_back(int'(credit_out.response_credits));
            last_resp_cyc = cyc;
         end
         if (cmd_out_valid && cmd_out_ready) last_pop_cyc = cyc;

         m_pop  = exp_valid && cmd_out_ready;
         m_full = (sb_q.size() == 32);
         m_push = (m_state == 2) && request_valid && (!m_full || m_pop);
         if ((m_state == 2) && request_valid && m_full && !m_pop) m_overrun = 1;
         if (m_pop) void'(sb_q.pop_front());
         if (m_push) sb_q.push_back(request_payload);
         m_echo = m_push;
         if (m_ret || m_pend == 0) m_tmr = 0;
         else if (m_tmr < 15) m_tmr++;
         m_pend = m_ret ? int'(m_pop) : m_pend + int'(m_pop);
         if (m_state == 0 && enable) m_state = 1;
         else if (m_state == 1) m_state = 2;
      end
      cyc++;
   end

   task automatic tick(input bit req, input bit rdy);
      request_valid   = req;
      cmd_out_ready   = rdy;
      request_payload = {$urandom, $urandom};
      @(posedge clock);
      #1;
   endtask

   int b_echo, b_cnt, b_sum, b_log;

   initial begin
      #2 rstn = 1'b0;
      repeat (2) @(posedge clock);
      #1 rstn = 1'b1;

      // Requests while idle are ignored
      tick(1, 0);
      tick(1, 0);
      check_eq("idle_occ", occupancy, 0);
      request_valid = 1'b0;
      enable = 1'b1;
      #2 check_eq("room_enable_cycle", credit_out.room, 0);
      @(posedge clock); #1;
      check_eq("room_announce", credit_out.room, 8'h20);
      tick(0, 0);

      // Four requests, consumer always ready: one batch of 4
      b_echo = echo_cnt; b_cnt = resp_cnt;
      repeat (4) tick(1, 1);
      repeat (4) tick(0, 1);
      check_eq("b_echoes", echo_cnt - b_echo, 4);
      check_eq("b_resp_cnt", resp_cnt - b_cnt, 1);
      check_eq("b_credits", resp_log[resp_log.size() - 1], 4);
      check_eq("b_latency", last_resp_cyc - last_pop_cyc, 1);

      // Single request then idle: returned on timeout
      b_cnt = resp_cnt;
      tick(1, 1);
      repeat (20) tick(0, 1);
      check_eq("t_resp_cnt", resp_cnt - b_cnt, 1);
      check_eq("t_credits", resp_log[resp_log.size() - 1], 1);
      check_eq("t_latency", last_resp_cyc - last_pop_cyc, 16);

      // Fill, overrun, drain
      b_echo = echo_cnt;
      repeat (32) tick(1, 0);
      check_eq("d_occ_full", occupancy, 32);
      tick(1, 0);
      tick(0, 0);
      check_eq("d_overrun", overrun_error, 1);
      check_eq("d_occ_after_drop", occupancy, 32);
      check_eq("d_echoes", echo_cnt - b_echo, 32);
      b_cnt = resp_cnt; b_sum = resp_sum;
      repeat (40) tick(0, 1);
      check_eq("d_sum", resp_sum - b_sum, 32);
      check_eq("d_resp_cnt", resp_cnt - b_cnt, 8);
      check_eq("d_occ_empty", occupancy, 0);

      // Pop lands in the same cycle as a timeout return of 3
      repeat (4) tick(1, 0);
      repeat (2) tick(0, 0);
      b_log = resp_log.size(); b_sum = resp_sum;
      repeat (3) tick(0, 1);
      repeat (13) tick(0, 0);
      tick(0, 1);
      repeat (20) tick(0, 0);
      check_eq("e_resp_cnt", resp_log.size() - b_log, 2);
      if (resp_log.size() >= b_log + 2) begin
         check_eq("e_first", resp_log[b_log], 3);
         check_eq("e_second", resp_log[b_log + 1], 1);
      end
      check_eq("e_sum", resp_sum - b_sum, 4);

      // Reset mid-drain with occupancy 10, pending 2
      repeat (12) tick(1, 0);
      repeat (2) tick(0, 1);
      check_eq("f_occ_before", occupancy, 10);
      request_valid = 1'b0;
      cmd_out_ready = 1'b0;
      rstn = 1'b0;
      #1;
      check_eq("f_valid", cmd_out_valid, 0);
      check_eq("f_payload", cmd_out_payload, 0);
      check_eq("f_occ", occupancy, 0);
      check_eq("f_credit_out", credit_out, 0);
      check_eq("f_overrun", overrun_error, 0);
      repeat (2) @(posedge clock);
      #1 rstn = 1'b1;
      b_cnt = resp_cnt;
      repeat (3) tick(0, 0);
      check_eq("f_room", credit_out.room, 8'h20);
      check_eq("f_occ_after", occupancy, 0);
      repeat (20) tick(0, 1);
      check_eq("f_no_stale_resp", resp_cnt - b_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
